// File: rtl/axi_wr_issue_pkg.sv
// Shared definitions for the AXI write-issue stage: FSM encoding, burst geometry
// and the beat-counter width helper.
package axi_wr_issue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int BEATS_DEFAULT = 4;
    localparam int BL8_BYTES     = 16;

    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/axi_wr_issue_wr_last_check.sv
// Sticky checker for write-data packets whose last marker misses a BL8 boundary.
// Only instantiated when AXI_WR_ISSUE_LAST_CHECK_EN is defined.
module wr_last_check
    import axi_wr_issue_pkg::*;
#(
    parameter int BEATS = BEATS_DEFAULT,
    parameter int CW    = beat_cnt_width(BEATS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          xfer_i,
    input  logic [CW-1:0] beat_i,
    input  logic          last_i,
    input  logic          store_i,
    input  logic          wseq_i,
    output logic          err_o
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic err_q, err_d;
    logic pend_q, pend_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    // A packet left open at a burst end is only an error if the next head starts a new burst.
    always_comb begin
        err_d  = err_q;
        pend_d = 1'b0;
        if (xfer_i && last_i && (beat_i != LAST_BEAT)) begin
            err_d = 1'b1;
        end
        if (xfer_i && !last_i && (beat_i == LAST_BEAT)) begin
            pend_d = 1'b1;
        end
        if (pend_q && store_i && !wseq_i) begin
            err_d = 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/axi_wr_issue.sv
// Write-issue stage: pops one BL8 write command, requests a WRITE, then streams BEATS words.
// Define AXI_WR_ISSUE_LAST_CHECK_EN to compile in the last-marker alignment checker.
module axi_wr_issue
    import axi_wr_issue_pkg::*;
#(
    parameter int ADDRS        = 32,
    parameter int WIDTH        = 32,
    parameter int MASKS        = WIDTH / 8,
    parameter int AXI_ID_WIDTH = 4,
    parameter int BEATS        = BEATS_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_store_i,
    output logic                    mem_accept_o,
    input  logic                    mem_wseq_i,
    input  logic [AXI_ID_WIDTH-1:0] mem_wrid_i,
    input  logic [ADDRS-1:0]        mem_addr_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic                    mem_last_i,
    input  logic [MASKS-1:0]        mem_strb_i,
    input  logic [WIDTH-1:0]        mem_data_i,
    output logic                    ctl_req_o,
    input  logic                    ctl_gnt_i,
    output logic                    ctl_seq_o,
    output logic [AXI_ID_WIDTH-1:0] ctl_wrid_o,
    output logic [ADDRS-1:0]        ctl_addr_o,
    output logic                    wr_valid_o,
    input  logic                    wr_ready_i,
    output logic [MASKS-1:0]        wr_strb_o,
    output logic [WIDTH-1:0]        wr_data_o,
    output logic                    err_o
);

    localparam int            CW        = beat_cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xfer;

    assign xfer = (state_q == DATA) && mem_valid_i && wr_ready_i;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_store_i) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (req_q && ctl_gnt_i) begin
                    state_d = DATA;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Handshakes are masked while reset is low so an abandoned burst pops nothing more.
    always_comb begin
        mem_accept_o = 1'b0;
        mem_ready_o  = 1'b0;
        wr_valid_o   = 1'b0;
        if (reset) begin
            case (state_q)
                REQ: mem_accept_o = req_q && ctl_gnt_i;
                DATA: begin
                    wr_valid_o  = mem_valid_i;
                    mem_ready_o = wr_ready_i;
                end
                default: ;
            endcase
        end
    end

    assign ctl_req_o  = req_q && reset;
    assign ctl_seq_o  = mem_wseq_i;
    assign ctl_wrid_o = mem_wrid_i;
    assign ctl_addr_o = mem_addr_i;
    assign wr_strb_o  = mem_strb_i;
    assign wr_data_o  = mem_data_i;

`ifdef AXI_WR_ISSUE_LAST_CHECK_EN
    wr_last_check #(
        .BEATS (BEATS),
        .CW    (CW)
    ) u_last_check (
        .clock   (clock),
        .reset   (reset),
        .xfer_i  (xfer),
        .beat_i  (cnt_q),
        .last_i  (mem_last_i),
        .store_i (mem_store_i),
        .wseq_i  (mem_wseq_i),
        .err_o   (err_o)
    );
`else
    logic unused_last;
    assign unused_last = mem_last_i;
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_issue.sv
// Self-checking bench for axi_wr_issue: the bench plays both FIFOs and the controller,
// and a queue-based model predicts handshakes, request order, data order and err_o.
module tb_axi_wr_issue;
    import axi_wr_issue_pkg::*;

    localparam int ADDRS = 32;
    localparam int WIDTH = 32;
    localparam int MASKS = WIDTH / 8;
    localparam int IDW   = 4;
    localparam int BEATS = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             mem_store_i = 1'b0, mem_accept_o, mem_wseq_i = 1'b0;
    logic [IDW-1:0]   mem_wrid_i = '0;
    logic [ADDRS-1:0] mem_addr_i = '0;
    logic             mem_valid_i = 1'b0, mem_ready_o, mem_last_i = 1'b0;
    logic [MASKS-1:0] mem_strb_i = '0;
    logic [WIDTH-1:0] mem_data_i = '0;
    logic             ctl_req_o, ctl_gnt_i = 1'b0, ctl_seq_o;
    logic [IDW-1:0]   ctl_wrid_o;
    logic [ADDRS-1:0] ctl_addr_o;
    logic             wr_valid_o, wr_ready_i = 1'b0;
    logic [MASKS-1:0] wr_strb_o;
    logic [WIDTH-1:0] wr_data_o;
    logic             err_o;

    axi_wr_issue #(
        .ADDRS(ADDRS), .WIDTH(WIDTH), .MASKS(MASKS), .AXI_ID_WIDTH(IDW), .BEATS(BEATS)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_store_i(mem_store_i), .mem_accept_o(mem_accept_o), .mem_wseq_i(mem_wseq_i),
        .mem_wrid_i(mem_wrid_i), .mem_addr_i(mem_addr_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_last_i(mem_last_i),
        .mem_strb_i(mem_strb_i), .mem_data_i(mem_data_i),
        .ctl_req_o(ctl_req_o), .ctl_gnt_i(ctl_gnt_i), .ctl_seq_o(ctl_seq_o),
        .ctl_wrid_o(ctl_wrid_o), .ctl_addr_o(ctl_addr_o),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_strb_o(wr_strb_o), .wr_data_o(wr_data_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             seq;
        logic [IDW-1:0]   id;
        logic [ADDRS-1:0] addr;
    } cmd_t;

    typedef struct packed {
        logic             last;
        logic [MASKS-1:0] strb;
        logic [WIDTH-1:0] data;
    } word_t;

    cmd_t  cmd_q[$];
    word_t dat_q[$];
    int    req_rise[$];
    int    beat_end[$];
    int    xfer_cyc[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   words_out = 0;
    int   req_cycles = 0;
    int   ready_mode = 0;
    int   valid_gap_pct = 0;
    int   gnt_delay = 0;
    int   req_wait = 0;
    int   beats_left = 0;
    logic gnt_noise = 1'b0;
    logic toggle = 1'b1;
    logic rst_req = 1'b1;
    logic prev_req = 1'b0;
    logic exp_req = 1'b0;
    logic exp_err = 1'b0;
    logic pend_last = 1'b0;

    function automatic void push_cmd(input logic [ADDRS-1:0] addr, input logic [IDW-1:0] id,
                                     input logic seq);
        cmd_t c;
        c.seq  = seq;
        c.id   = id;
        c.addr = addr;
        cmd_q.push_back(c);
    endfunction

    function automatic void push_word(input logic [WIDTH-1:0] data, input logic [MASKS-1:0] strb,
                                      input logic last);
        word_t w;
        w.last = last;
        w.strb = strb;
        w.data = data;
        dat_q.push_back(w);
    endfunction

    // One bench cycle: drive at negedge, check #1 later, then let the FIFOs react to the pops.
    task automatic cycle();
        logic grant, xfer, exp_val, exp_rdy, was_idle, nerr, npend;
        int   idx;
        @(negedge clock);
        reset = !rst_req;
        if (cmd_q.size() > 0) begin
            mem_store_i = 1'b1;
            mem_wseq_i  = cmd_q[0].seq;
            mem_wrid_i  = cmd_q[0].id;
            mem_addr_i  = cmd_q[0].addr;
        end else begin
            mem_store_i = 1'b0;
            mem_wseq_i  = 1'($urandom);
            mem_wrid_i  = IDW'($urandom);
            mem_addr_i  = $urandom;
        end
        if (dat_q.size() > 0) begin
            mem_valid_i = ($urandom_range(99) >= valid_gap_pct);
            mem_last_i  = dat_q[0].last;
            mem_strb_i  = dat_q[0].strb;
            mem_data_i  = dat_q[0].data;
        end else begin
            mem_valid_i = 1'b0;
            mem_last_i  = 1'($urandom);
            mem_strb_i  = MASKS'($urandom);
            mem_data_i  = $urandom;
        end
        case (ready_mode)
            0: wr_ready_i = 1'b1;
            1: begin
                wr_ready_i = toggle;
                toggle     = !toggle;
            end
            default: wr_ready_i = 1'($urandom);
        endcase
        if (ctl_req_o === 1'b1) begin
            ctl_gnt_i = (req_wait >= gnt_delay);
            req_wait++;
        end else begin
            ctl_gnt_i = gnt_noise & 1'($urandom);
            req_wait  = 0;
        end
        #1;
        cyc++;
        if (ctl_req_o === 1'b1) req_cycles++;
        if (ctl_req_o === 1'b1 && !prev_req) req_rise.push_back(cyc);
        prev_req = (ctl_req_o === 1'b1);

        if (!reset) begin
            checks += 5;
            if (ctl_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", ctl_req_o); end
            if (mem_accept_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_accept: got %b expected 0", mem_accept_o); end
            if (wr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", wr_valid_o); end
            if (mem_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", mem_ready_o); end
            if (err_o !== exp_err) begin errors++; $display("[TB] FAIL rst_err: got %b expected %b", err_o, exp_err); end
            exp_req    = 1'b0;
            beats_left = 0;
            pend_last  = 1'b0;
            exp_err    = 1'b0;
        end else begin
            was_idle = !exp_req && (beats_left == 0);
            grant    = exp_req && ctl_gnt_i;
            exp_val  = (beats_left > 0) && mem_valid_i;
            exp_rdy  = (beats_left > 0) && wr_ready_i;
            xfer     = exp_val && wr_ready_i;
            checks += 5;
            if (ctl_req_o !== exp_req) begin errors++; $display("[TB] FAIL req @%0d: got %b expected %b", cyc, ctl_req_o, exp_req); end
            if (mem_accept_o !== grant) begin errors++; $display("[TB] FAIL accept @%0d: got %b expected %b", cyc, mem_accept_o, grant); end
            if (wr_valid_o !== exp_val) begin errors++; $display("[TB] FAIL wr_valid @%0d: got %b expected %b", cyc, wr_valid_o, exp_val); end
            if (mem_ready_o !== exp_rdy) begin errors++; $display("[TB] FAIL mem_ready @%0d: got %b expected %b", cyc, mem_ready_o, exp_rdy); end
            if (err_o !== exp_err) begin errors++; $display("[TB] FAIL err @%0d: got %b expected %b", cyc, err_o, exp_err); end
            if (grant && cmd_q.size() > 0) begin
                checks += 3;
                if (ctl_addr_o !== cmd_q[0].addr) begin errors++; $display("[TB] FAIL addr @%0d: got %h expected %h", cyc, ctl_addr_o, cmd_q[0].addr); end
                if (ctl_wrid_o !== cmd_q[0].id) begin errors++; $display("[TB] FAIL wrid @%0d: got %h expected %h", cyc, ctl_wrid_o, cmd_q[0].id); end
                if (ctl_seq_o !== cmd_q[0].seq) begin errors++; $display("[TB] FAIL seq @%0d: got %b expected %b", cyc, ctl_seq_o, cmd_q[0].seq); end
            end
            if (xfer) begin
                checks += 2;
                if (wr_data_o !== dat_q[0].data) begin errors++; $display("[TB] FAIL data @%0d: got %h expected %h", cyc, wr_data_o, dat_q[0].data); end
                if (wr_strb_o !== dat_q[0].strb) begin errors++; $display("[TB] FAIL strb @%0d: got %h expected %h", cyc, wr_strb_o, dat_q[0].strb); end
            end
            nerr  = exp_err;
            npend = 1'b0;
            if (pend_last && mem_store_i && !mem_wseq_i) nerr = 1'b1;
            if (xfer) begin
                idx = BEATS - beats_left;
                if (mem_last_i && idx != BEATS - 1) nerr = 1'b1;
                if (!mem_last_i && idx == BEATS - 1) npend = 1'b1;
            end
`ifdef AXI_WR_ISSUE_LAST_CHECK_EN
            exp_err = nerr;
`endif
            pend_last = npend;
            if (grant) begin
                exp_req    = 1'b0;
                beats_left = BEATS;
            end else if (was_idle && mem_store_i) begin
                exp_req = 1'b1;
            end
            if (xfer) begin
                beats_left--;
                words_out++;
                xfer_cyc.push_back(cyc);
                if (beats_left == 0) beat_end.push_back(cyc);
            end
        end
        if (mem_accept_o === 1'b1 && cmd_q.size() > 0) begin
            void'(cmd_q.pop_front());
            accepts++;
        end
        if (mem_ready_o === 1'b1 && mem_valid_i && dat_q.size() > 0) void'(dat_q.pop_front());
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((cmd_q.size() > 0 || dat_q.size() > 0 || beats_left > 0 || exp_req) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL timeout: got %0d cycles expected fewer than %0d", n, budget);
        end
        cycle();
        cycle();
    endtask

    task automatic set_knobs(input int rm, input int gap, input int gd, input logic noise);
        ready_mode    = rm;
        valid_gap_pct = gap;
        gnt_delay     = gd;
        gnt_noise     = noise;
        req_rise.delete();
        beat_end.delete();
        xfer_cyc.delete();
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        repeat (3) cycle();
        rst_req = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic test_single();
        int a0, w0;
        set_knobs(0, 0, 0, 1'b0);
        a0 = accepts;
        w0 = words_out;
        push_cmd(32'h100, 4'd3, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word(WIDTH'(32'hA0 + i), 4'hF, i == BEATS - 1);
        run_until_idle(40);
        checks += 3;
        if (accepts - a0 != 1) begin errors++; $display("[TB] FAIL single_accepts: got %0d expected 1", accepts - a0); end
        if (words_out - w0 != BEATS) begin errors++; $display("[TB] FAIL single_words: got %0d expected %0d", words_out - w0, BEATS); end
        if (xfer_cyc.size() != BEATS || xfer_cyc[BEATS-1] - xfer_cyc[0] != BEATS - 1) begin
            errors++;
            $display("[TB] FAIL single_consecutive: got %0d transfers expected %0d in consecutive cycles", xfer_cyc.size(), BEATS);
        end
    endtask

    task automatic test_burst();
        int a0;
        set_knobs(0, 0, 0, 1'b0);
        a0 = accepts;
        for (int k = 0; k < 4; k++) begin
            push_cmd(ADDRS'(32'h2000 + k * BL8_BYTES), 4'd5, k != 0);
            for (int i = 0; i < BEATS; i++) push_word($urandom, MASKS'($urandom), (k == 3) && (i == BEATS - 1));
        end
        run_until_idle(100);
        checks += 2;
        if (accepts - a0 != 4) begin errors++; $display("[TB] FAIL burst_accepts: got %0d expected 4", accepts - a0); end
        if (req_rise.size() != 4) begin errors++; $display("[TB] FAIL burst_requests: got %0d expected 4", req_rise.size()); end
    endtask

    task automatic test_gnt_delay();
        int a0, r0;
        set_knobs(0, 0, 5, 1'b0);
        a0 = accepts;
        r0 = req_cycles;
        push_cmd(32'h340, 4'd9, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, i == BEATS - 1);
        run_until_idle(60);
        checks += 2;
        if (req_cycles - r0 != 6) begin errors++; $display("[TB] FAIL gnt_delay_req_cycles: got %0d expected 6", req_cycles - r0); end
        if (accepts - a0 != 1) begin errors++; $display("[TB] FAIL gnt_delay_accepts: got %0d expected 1", accepts - a0); end
    endtask

    task automatic test_backpressure();
        int w0;
        set_knobs(1, 40, 1, 1'b1);
        w0 = words_out;
        push_cmd(32'h480, 4'd1, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, MASKS'($urandom), i == BEATS - 1);
        run_until_idle(200);
        checks++;
        if (words_out - w0 != BEATS) begin errors++; $display("[TB] FAIL bp_words: got %0d expected %0d", words_out - w0, BEATS); end
    endtask

    task automatic test_back_to_back();
        set_knobs(0, 0, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            push_cmd(ADDRS'(32'h600 + k * BL8_BYTES), 4'd2, 1'b0);
            for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, i == BEATS - 1);
        end
        run_until_idle(60);
        checks++;
        if (req_rise.size() < 2 || beat_end.size() < 1 || req_rise[1] - beat_end[0] != 2) begin
            errors++;
            $display("[TB] FAIL b2b_gap: got %0d rises expected second request 2 cycles after last beat", req_rise.size());
        end
    endtask

    task automatic test_random();
        int a0, w0, ncmd;
        set_knobs(2, 25, $urandom_range(3), 1'b1);
        a0 = accepts;
        w0 = words_out;
        ncmd = 0;
        for (int p = 0; p < 6; p++) begin
            int chunks = $urandom_range(1, 3);
            logic [ADDRS-1:0] base = ADDRS'($urandom) & ~ADDRS'(BL8_BYTES - 1);
            logic [IDW-1:0] id = IDW'($urandom);
            for (int k = 0; k < chunks; k++) begin
                push_cmd(base + ADDRS'(k * BL8_BYTES), id, k != 0);
                ncmd++;
                for (int i = 0; i < BEATS; i++) push_word($urandom, MASKS'($urandom), (k == chunks - 1) && (i == BEATS - 1));
            end
        end
        run_until_idle(2000);
        checks += 2;
        if (accepts - a0 != ncmd) begin errors++; $display("[TB] FAIL rand_accepts: got %0d expected %0d", accepts - a0, ncmd); end
        if (words_out - w0 != ncmd * BEATS) begin errors++; $display("[TB] FAIL rand_words: got %0d expected %0d", words_out - w0, ncmd * BEATS); end
    endtask

    task automatic test_reset_mid();
        int w0, n;
        set_knobs(0, 0, 0, 1'b0);
        w0 = words_out;
        n = 0;
        push_cmd(32'h700, 4'd6, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, i == BEATS - 1);
        while (words_out - w0 < 2 && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (words_out - w0 != 2) begin errors++; $display("[TB] FAIL mid_reset_reach: got %0d words expected 2", words_out - w0); end
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cmd_q.delete();
        dat_q.delete();
        repeat (2) cycle();
        w0 = words_out;
        push_cmd(32'h740, 4'd7, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, i == BEATS - 1);
        run_until_idle(40);
        checks++;
        if (words_out - w0 != BEATS) begin errors++; $display("[TB] FAIL mid_reset_after: got %0d expected %0d", words_out - w0, BEATS); end
    endtask

    task automatic test_last_err();
        logic want;
`ifdef AXI_WR_ISSUE_LAST_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        set_knobs(0, 0, 0, 1'b0);
        push_cmd(32'h800, 4'd4, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, 1'b0);
        push_cmd(32'h900, 4'd4, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, i == BEATS - 1);
        run_until_idle(60);
        checks++;
        if (err_o !== want) begin errors++; $display("[TB] FAIL err_open_packet: got %b expected %b", err_o, want); end
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        push_cmd(32'hA00, 4'd8, 1'b0);
        for (int i = 0; i < BEATS; i++) push_word($urandom, 4'hF, i == 1);
        run_until_idle(60);
        repeat (3) cycle();
        checks++;
        if (err_o !== want) begin errors++; $display("[TB] FAIL err_early_last: got %b expected %b", err_o, want); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_gnt_delay();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_last_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
